// File: rtl/rll_ctrl_pkg.sv
// Shared types and default dimensions for the logic-locked netlist query controller.
package rll_ctrl_pkg;

    localparam int KEY_W_DEF  = 32;
    localparam int PI_W_DEF   = 36;
    localparam int PO_W_DEF   = 7;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;
    localparam int SETTLE_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READY,
        ST_SETTLE,
        ST_RESP
    } rll_state_t;

endpackage

// File: rtl/rll_key_shifter.sv
// Serial key shadow register with bit counter; commits the full key atomically
// on the last valid beat so the netlist never sees a partial key.
module rll_key_shifter #(
    parameter int KEY_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             beat,
    input  logic             sdi,
    output logic [KEY_W-1:0] key_out,
    output logic             commit
);
    localparam int BW = (KEY_W > 1) ? $clog2(KEY_W) : 1;

    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;

    always_comb begin
        shadow_d = shadow_q;
        bitcnt_d = bitcnt_q;
        key_d    = key_q;
        commit   = 1'b0;
        if (clear) begin
            shadow_d = '0;
            bitcnt_d = '0;
        end else if (beat) begin
            shadow_d[bitcnt_q] = sdi;
            if (bitcnt_q == BW'(KEY_W - 1)) begin
                // the final bit lands in the committed key on the same edge
                commit   = 1'b1;
                bitcnt_d = '0;
                key_d    = shadow_d;
            end else begin
                bitcnt_d = bitcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            bitcnt_q <= '0;
            key_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            bitcnt_q <= bitcnt_d;
            key_q    <= key_d;
        end
    end

    assign key_out = key_q;

endmodule

// File: rtl/rll_key_query_ctrl.sv
// Key-load and query sequencer in front of a combinational logic-locked netlist:
// drives key/inputs, waits a settle time, captures and returns the outputs.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no key yet; queries ignored
// ST_LOAD   | shifting key bits into the shadow register
// ST_READY  | key committed; accepting a query
// ST_SETTLE | netlist inputs driven; settle timer counting down
// ST_RESP   | captured outputs held until the requester takes them
module rll_key_query_ctrl
    import rll_ctrl_pkg::*;
#(
    parameter int KEY_W  = KEY_W_DEF,
    parameter int PI_W   = PI_W_DEF,
    parameter int PO_W   = PO_W_DEF,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_load_start,
    input  logic             key_sdi,
    input  logic             key_sdi_valid,
    input  logic             query_valid,
    output logic             query_ready,
    input  logic [PI_W-1:0]  query_pi,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [PO_W-1:0]  resp_po,
    output logic [KEY_W-1:0] key_out,
    output logic [PI_W-1:0]  pi_out,
    input  logic [PO_W-1:0]  po_in,
    output logic             key_loaded,
    output logic [CNT_W-1:0] query_count
);
    rll_state_t          state_q, state_d;
    logic [PI_W-1:0]     pi_q, pi_d;
    logic [PO_W-1:0]     resp_po_q, resp_po_d;
    logic                resp_valid_q, resp_valid_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                key_loaded_q, key_loaded_d;
    logic                query_ready_q, query_ready_d;
    logic                key_clear, key_beat, key_commit;

    // a load request is honoured only where a key load may begin or restart
    assign key_clear = key_load_start &&
                       (state_q == ST_IDLE || state_q == ST_LOAD || state_q == ST_READY);
    assign key_beat  = key_sdi_valid && (state_q == ST_LOAD);

    rll_key_shifter #(.KEY_W(KEY_W)) u_key_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (key_clear),
        .beat    (key_beat),
        .sdi     (key_sdi),
        .key_out (key_out),
        .commit  (key_commit)
    );

    always_comb begin
        state_d      = state_q;
        pi_d         = pi_q;
        resp_po_d    = resp_po_q;
        resp_valid_d = resp_valid_q;
        settle_d     = settle_q;
        cnt_d        = cnt_q;
        key_loaded_d = key_loaded_q;
        case (state_q)
            ST_IDLE: begin
                if (key_load_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (key_commit) begin
                    key_loaded_d = 1'b1;
                    state_d      = ST_READY;
                end
            end
            ST_READY: begin
                if (key_load_start) begin
                    key_loaded_d = 1'b0;
                    state_d      = ST_LOAD;
                end else if (query_valid && query_ready_q) begin
                    pi_d     = query_pi;
                    settle_d = SETTLE_W'(SETTLE);
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                settle_d = settle_q - 1'b1;
                if (settle_q == SETTLE_W'(1)) begin
                    resp_po_d    = po_in;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        query_ready_d = (state_d == ST_READY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pi_q          <= '0;
            resp_po_q     <= '0;
            resp_valid_q  <= 1'b0;
            settle_q      <= '0;
            cnt_q         <= '0;
            key_loaded_q  <= 1'b0;
            query_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pi_q          <= pi_d;
            resp_po_q     <= resp_po_d;
            resp_valid_q  <= resp_valid_d;
            settle_q      <= settle_d;
            cnt_q         <= cnt_d;
            key_loaded_q  <= key_loaded_d;
            query_ready_q <= query_ready_d;
        end
    end

    assign query_ready = query_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_po     = resp_po_q;
    assign pi_out      = pi_q;
    assign key_loaded  = key_loaded_q;
    assign query_count = cnt_q;

endmodule

// File: tb/tb_rll_key_query_ctrl.sv
// Bench for rll_key_query_ctrl: a model locked netlist is attached to the DUT,
// expected responses go through a scoreboard queue; a CNT_W=4 twin checks saturation.
module tb_rll_key_query_ctrl;
    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_load_start = 1'b0;
    logic        key_sdi = 1'b0;
    logic        key_sdi_valid = 1'b0;
    logic        query_valid = 1'b0;
    logic [35:0] query_pi = '0;
    logic        resp_ready = 1'b0;

    logic        query_ready, resp_valid, key_loaded;
    logic [6:0]  resp_po, po_in;
    logic [31:0] key_out;
    logic [35:0] pi_out;
    logic [15:0] query_count;

    logic        query_ready4, resp_valid4, key_loaded4;
    logic [6:0]  resp_po4, po_in4;
    logic [31:0] key_out4;
    logic [35:0] pi_out4;
    logic [3:0]  query_count4;

    int          tests = 0;
    int          fails = 0;
    logic [6:0]  sb[$];
    logic [31:0] cur_key = '0;
    int          cnt_model = 0;

    always #5 clk = ~clk;

    function automatic logic [6:0] netlist(input logic [31:0] k, input logic [35:0] p);
        logic [35:0] x;
        logic [6:0]  r;
        x = p ^ {k[3:0], k};
        for (int i = 0; i < 7; i++)
            r[i] = x[i] ^ x[i+7] ^ x[i+14] ^ (x[i+21] & x[i+28]);
        return r;
    endfunction

    assign po_in  = netlist(key_out, pi_out);
    assign po_in4 = netlist(key_out4, pi_out4);

    rll_key_query_ctrl #(.SETTLE(SETTLE), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .key_load_start(key_load_start), .key_sdi(key_sdi),
        .key_sdi_valid(key_sdi_valid), .query_valid(query_valid), .query_ready(query_ready),
        .query_pi(query_pi), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_po(resp_po), .key_out(key_out), .pi_out(pi_out), .po_in(po_in),
        .key_loaded(key_loaded), .query_count(query_count)
    );

    rll_key_query_ctrl #(.SETTLE(SETTLE), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .key_load_start(key_load_start), .key_sdi(key_sdi),
        .key_sdi_valid(key_sdi_valid), .query_valid(query_valid), .query_ready(query_ready4),
        .query_pi(query_pi), .resp_valid(resp_valid4), .resp_ready(resp_ready),
        .resp_po(resp_po4), .key_out(key_out4), .pi_out(pi_out4), .po_in(po_in4),
        .key_loaded(key_loaded4), .query_count(query_count4)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [31:0] k, input logic [31:0] old, input bit do_start);
        if (do_start) begin
            key_load_start = 1'b1;
            cyc();
            key_load_start = 1'b0;
        end
        for (int i = 0; i < 32; i++) begin
            if (i == 5) begin
                key_sdi_valid = 1'b0;
                cyc();
            end
            key_sdi = k[i];
            key_sdi_valid = 1'b1;
            cyc();
            if (i < 31) begin
                tests++;
                if (key_out !== old || key_loaded !== 1'b0) begin
                    fails++;
                    $display("FAIL key_hold beat %0d: key_out=%h loaded=%b, want %h loaded=0", i, key_out, key_loaded, old);
                end
            end
        end
        key_sdi_valid = 1'b0;
        tests++;
        if (key_out !== k || key_loaded !== 1'b1 || query_ready !== 1'b1) begin
            fails++;
            $display("FAIL key_commit: key_out=%h loaded=%b qrdy=%b, want %h 1 1", key_out, key_loaded, query_ready, k);
        end
        cur_key = k;
    endtask

    task automatic do_query(input logic [35:0] pi, input int hold);
        int n;
        logic [6:0] exp_po, held;
        n = 0;
        while (!query_ready && n < 50) begin cyc(); n++; end
        tests++;
        if (query_ready !== 1'b1) begin
            fails++;
            $display("FAIL qready_wait: query_ready=%b want 1", query_ready);
        end
        query_pi = pi;
        query_valid = 1'b1;
        sb.push_back(netlist(cur_key, pi));
        cyc();
        query_valid = 1'b0;
        tests++;
        if (pi_out !== pi || query_ready !== 1'b0) begin
            fails++;
            $display("FAIL pi_out_T1: pi_out=%h qrdy=%b want %h 0", pi_out, query_ready, pi);
        end
        n = 1;
        while (!resp_valid && n < 40) begin cyc(); n++; end
        tests++;
        if (n !== SETTLE + 1) begin
            fails++;
            $display("FAIL resp_latency: %0d cycles want %0d", n, SETTLE + 1);
        end
        exp_po = (sb.size() > 0) ? sb.pop_front() : 7'hxx;
        tests++;
        if (resp_po !== exp_po || resp_valid !== 1'b1) begin
            fails++;
            $display("FAIL resp_po: got %h valid=%b want %h", resp_po, resp_valid, exp_po);
        end
        held = resp_po;
        for (int h = 0; h < hold; h++) begin
            cyc();
            tests++;
            if (resp_valid !== 1'b1 || resp_po !== held || query_ready !== 1'b0) begin
                fails++;
                $display("FAIL backpressure %0d: valid=%b po=%h qrdy=%b want 1 %h 0", h, resp_valid, resp_po, query_ready, held);
            end
        end
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        cnt_model++;
        tests++;
        if (resp_valid !== 1'b0 || query_ready !== 1'b1 || query_count !== 16'(cnt_model)
            || query_count4 !== 4'((cnt_model > 15) ? 15 : cnt_model)) begin
            fails++;
            $display("FAIL resp_done: valid=%b qrdy=%b cnt=%0d cnt4=%0d want 0 1 %0d", resp_valid, query_ready, query_count, query_count4, cnt_model);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        tests++;
        if (key_out !== '0 || pi_out !== '0 || resp_po !== '0 || query_count !== '0
            || query_ready !== 1'b0 || resp_valid !== 1'b0 || key_loaded !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: key=%h pi=%h po=%h cnt=%0d qr=%b rv=%b kl=%b want all 0", key_out, pi_out, resp_po, query_count, query_ready, resp_valid, key_loaded);
        end
    endtask

    task automatic test_key_load();
        load_key(32'hA5C3_0F1E, 32'h0, 1'b1);
    endtask

    task automatic test_single_query();
        do_query(36'h9_1234_5678, 0);
    endtask

    task automatic test_backpressure();
        do_query(36'h3_0BAD_F00D, 10);
    endtask

    task automatic test_reload_priority();
        logic [35:0] prev_pi;
        prev_pi = pi_out;
        key_load_start = 1'b1;
        query_valid = 1'b1;
        query_pi = 36'hF_FFFF_FFFF;
        cyc();
        key_load_start = 1'b0;
        query_valid = 1'b0;
        tests++;
        if (key_loaded !== 1'b0 || query_ready !== 1'b0 || pi_out !== prev_pi) begin
            fails++;
            $display("FAIL reload_priority: kl=%b qr=%b pi=%h want 0 0 %h", key_loaded, query_ready, pi_out, prev_pi);
        end
        load_key(32'h0000_FFFF, 32'hA5C3_0F1E, 1'b0);
        do_query(36'hA_5555_AAAA, 0);
    endtask

    task automatic test_restart();
        key_load_start = 1'b1;
        cyc();
        key_load_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            key_sdi = 1'($urandom);
            key_sdi_valid = 1'b1;
            cyc();
        end
        key_sdi_valid = 1'b0;
        load_key(32'h0000_0001, 32'h0000_FFFF, 1'b1);
    endtask

    task automatic test_reset_abort();
        query_pi = 36'h1_2345_6789;
        query_valid = 1'b1;
        cyc();
        query_valid = 1'b0;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (key_out !== '0 || pi_out !== '0 || resp_po !== '0 || query_count !== '0
            || query_ready !== 1'b0 || resp_valid !== 1'b0 || key_loaded !== 1'b0) begin
            fails++;
            $display("FAIL reset_abort: key=%h pi=%h po=%h cnt=%0d qr=%b rv=%b kl=%b want all 0", key_out, pi_out, resp_po, query_count, query_ready, resp_valid, key_loaded);
        end
        sb.delete();
        cnt_model = 0;
        cur_key = '0;
        cyc();
        rst_n = 1'b1;
        query_valid = 1'b1;
        repeat (3) cyc();
        query_valid = 1'b0;
        tests++;
        if (query_ready !== 1'b0 || pi_out !== '0 || resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_ignores_query: qr=%b pi=%h rv=%b want 0 0 0", query_ready, pi_out, resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int got, cyc_i, last_hs;
        logic [6:0] exp_po;
        load_key(32'h3C96_A55A, 32'h0, 1'b1);
        got = 0; cyc_i = 0; last_hs = -1;
        resp_ready = 1'b1;
        query_valid = 1'b1;
        while (got < 20 && cyc_i < 500) begin
            query_pi = {4'($urandom), 32'($urandom)};
            if (query_ready) begin
                sb.push_back(netlist(cur_key, query_pi));
                if (last_hs >= 0) begin
                    tests++;
                    if (cyc_i - last_hs !== SETTLE + 2) begin
                        fails++;
                        $display("FAIL throughput: interval %0d want %0d", cyc_i - last_hs, SETTLE + 2);
                    end
                end
                last_hs = cyc_i;
            end
            if (resp_valid) begin
                exp_po = (sb.size() > 0) ? sb.pop_front() : 7'hxx;
                tests++;
                if (resp_po !== exp_po) begin
                    fails++;
                    $display("FAIL b2b_resp %0d: got %h want %h", got, resp_po, exp_po);
                end
                got++;
                cnt_model++;
            end
            cyc();
            cyc_i++;
        end
        query_valid = 1'b0;
        resp_ready = 1'b0;
        tests++;
        if (got !== 20 || query_count !== 16'(cnt_model) || query_count4 !== 4'd15) begin
            fails++;
            $display("FAIL saturation: got=%0d cnt=%0d cnt4=%0d want 20 %0d 15", got, query_count, query_count4, cnt_model);
        end
    endtask

    initial begin
        test_reset();
        test_key_load();
        test_single_query();
        test_backpressure();
        test_reload_priority();
        test_restart();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rll_key_query_ctrl.md
# rll_key_query_ctrl

Sequential controller in front of a combinational logic-locked benchmark netlist with 32 key inputs, 36 primary inputs and 7 primary outputs. It shifts a key in serially and commits it atomically to the key inputs, then serves input-vector queries through valid/ready handshakes. For each query it drives the inputs, waits a programmable settle time, captures the outputs and returns them. The simulator uses it as the oracle or attack-evaluation front end.

## Interface
- `KEY_W`, 32, key width; sets the width of `key_out`.
- `PI_W`, 36, netlist primary-input width.
- `PO_W`, 7, netlist primary-output width.
- `SETTLE`, 2, cycles the outputs are allowed to settle before capture; legal range 1..15.
- `CNT_W`, 16, width of the query counter.

Ports:
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_load_start`  in  1  pulse that begins a key load.
- `key_sdi`  in  1  serial key bit, LSB (keyinput0) first.
- `key_sdi_valid`  in  1  `key_sdi` is valid this cycle.
- `query_valid`  in  1  requester offers a query.
- `query_ready`  out  1  controller can accept a query.
- `query_pi`  in  PI_W  input vector for the query.
- `resp_valid`  out  1  a response is available.
- `resp_ready`  in  1  requester accepts the response.
- `resp_po`  out  PO_W  captured output vector.
- `key_out`  out  KEY_W  drives the netlist key inputs.
- `pi_out`  out  PI_W  drives the netlist primary inputs.
- `po_in`  in  PO_W  netlist primary outputs.
- `key_loaded`  out  1  a committed key is present.
- `query_count`  out  CNT_W  number of completed responses; saturates at its maximum.

## Operation
State machine states: IDLE, LOAD, READY, SETTLE, RESP.

- **IDLE**
  - `key_load_start` → LOAD. The bit counter and shadow register are cleared.
  - Query inputs are ignored.
- **LOAD**
  - Each cycle with `key_sdi_valid` high: `shadow[bitcnt] <= key_sdi`, and `bitcnt` increments.
  - On the KEY_W-th valid beat, at that same edge: `key_out <= shadow` (including the final bit), `key_loaded <= 1`, state → READY.
  - `key_load_start` while in LOAD restarts the load: counter and shadow are cleared.
  - `key_out` keeps its previous value until the commit edge.
- **READY**
  - `query_ready = 1`.
  - On `query_valid && query_ready`: `pi_out <= query_pi`, the settle counter is loaded with SETTLE, state → SETTLE.
  - `key_load_start` → LOAD and clears `key_loaded`. It takes priority over a simultaneous query; that query is not accepted.
- **SETTLE**
  - The settle counter decrements each cycle.
  - At the edge where it reaches 0: `resp_po <= po_in`, `resp_valid <= 1`, state → RESP.
- **RESP**
  - `resp_valid` and `resp_po` are held stable until `resp_ready`.
  - On the handshake: `resp_valid <= 0`, `query_count` increments (saturating), state → READY.
- `key_load_start` in SETTLE or RESP is ignored and not queued.
- `query_ready` is 0 in every state other than READY.
- `pi_out` holds its last query value between queries.

## Timing
- Reset values:
  - State is IDLE.
  - `key_out`, shadow, `bitcnt`, `pi_out`, `resp_po` and `query_count` are 0.
  - `query_ready`, `resp_valid` and `key_loaded` are 0.
- Reset asserted mid-load or mid-query returns everything to the reset values. No partial key is ever committed.
- Key load needs exactly KEY_W valid beats. Gaps with `key_sdi_valid = 0` are allowed.
- Query latency:
  - The handshake happens in cycle T.
  - `pi_out` is updated at the end of T.
  - `po_in` is sampled at the end of cycle T+SETTLE.
  - `resp_valid` is visible from cycle T+SETTLE+1.
- Throughput is at most one query per SETTLE+2 cycles, when `resp_ready` is held high.
- `query_ready` is a registered state decode; it does not depend combinationally on `query_valid`.
- `query_count` updates at the response handshake edge. Once it reaches its maximum it stays there.

## Structure
- Package `rll_ctrl_pkg` holds:
  - the state enum `rll_state_t`;
  - default width constants: KEY_W 32, PI_W 36, PO_W 7;
  - the SETTLE bounds.
- Sub-module `rll_key_shifter` holds the shadow register, the bit counter, the commit pulse and the restart logic. The top level holds the FSM, the query/response datapath and the counter.

## Test plan
- **Reset and key load:** release reset, then shift key 32'hA5C3_0F1E LSB first.
  - `key_out` = 32'hA5C3_0F1E, `key_loaded` = 1 and `query_ready` = 1 in the cycle after the 32nd beat.
  - `key_out` stays 0 before that.
- **Single query, SETTLE = 2:** `query_pi` = 36'h9_1234_5678 with the model netlist attached.
  - `pi_out` matches from T+1.
  - `resp_valid` rises at T+3 with `resp_po` equal to the golden model output.
  - `query_count` = 1 after the response handshake.
- **Back-pressure:** hold `resp_ready` = 0 for 10 cycles.
  - `resp_valid` and `resp_po` stay stable and `query_ready` = 0.
  - On release, `query_ready` returns the next cycle.
- **Reload and priority:**
  - `key_load_start` together with `query_valid` in READY: the query is not accepted and `key_loaded` drops.
  - Reload with 32'h0000_FFFF: old key held for 31 beats, new key after the 32nd.
- **Restart and reset abort:**
  - `key_load_start` after 10 beats, then 32 beats of 32'h1: commits 32'h1.
  - `rst_n` low mid-SETTLE: all outputs return to 0 asynchronously.
- **Saturation (CNT_W = 4 build):** run 20 queries → `query_count` stops at 15.
